// File: rtl/ysyx_25060170_pkg.sv
// Shared types and widths for the writeback unit: source IDs and the buffered result entry.
package ysyx_25060170_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NREG = 1 << RAW;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic            wen;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_25060170_wbu_if.sv
// Bundle of the writeback unit's result, GPR-write, hazard-query and commit signals.
interface ysyx_25060170_wbu_if;
  import ysyx_25060170_pkg::*;

  logic            exu_valid;
  logic            exu_ready;
  logic [RAW-1:0]  exu_rd;
  logic            exu_wen;
  logic [XLEN-1:0] exu_data;
  logic [XLEN-1:0] exu_pc;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [RAW-1:0]  lsu_rd;
  logic            lsu_wen;
  logic [XLEN-1:0] lsu_data;
  logic [XLEN-1:0] lsu_pc;

  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            rf_wen;

  logic            iss_valid;
  logic [RAW-1:0]  iss_rd;
  logic [RAW-1:0]  qry_raddr1;
  logic [RAW-1:0]  qry_raddr2;
  logic            qry_busy1;
  logic            qry_busy2;

  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     instret;

  // The writeback unit itself.
  modport slave (
    input  exu_valid, exu_rd, exu_wen, exu_data, exu_pc,
    input  lsu_valid, lsu_rd, lsu_wen, lsu_data, lsu_pc,
    input  iss_valid, iss_rd, qry_raddr1, qry_raddr2,
    output exu_ready, lsu_ready,
    output rf_waddr, rf_wdata, rf_wen,
    output qry_busy1, qry_busy2,
    output commit_valid, commit_pc, instret
  );

  // The surrounding pipeline (EXU/LSU/IDU/GPR file).
  modport master (
    output exu_valid, exu_rd, exu_wen, exu_data, exu_pc,
    output lsu_valid, lsu_rd, lsu_wen, lsu_data, lsu_pc,
    output iss_valid, iss_rd, qry_raddr1, qry_raddr2,
    input  exu_ready, lsu_ready,
    input  rf_waddr, rf_wdata, rf_wen,
    input  qry_busy1, qry_busy2,
    input  commit_valid, commit_pc, instret
  );

endinterface

// File: rtl/ysyx_25060170_wb_buf.sv
// One-entry valid/ready holding register; can drain and refill in the same cycle.
module ysyx_25060170_wb_buf
  import ysyx_25060170_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  input  logic      drain,
  output logic      full,
  output wb_entry_t entry
);

  logic      full_q, full_d;
  wb_entry_t entry_q, entry_d;
  logic      load_s;

  // Ready only looks at buffer state so it never combinationally follows valid.
  assign in_ready = !rst && (!full_q || drain);
  assign load_s   = in_valid && in_ready;

  // Next-state for the full flag and stored entry.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (load_s) begin
      full_d  = 1'b1;
      entry_d = in_entry;
    end else if (drain) begin
      full_d  = 1'b0;
    end else begin
      full_d  = full_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full  = full_q;
  assign entry = entry_q;

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Writeback unit: buffers EXU/LSU results, arbitrates one GPR write per cycle,
// tracks pending-write scoreboard and emits a registered commit pulse.
module ysyx_25060170_wbu
  import ysyx_25060170_pkg::*;
(
  input logic               clk,
  input logic               rst,
  ysyx_25060170_wbu_if.slave bus
);

  wb_entry_t exu_in_s, lsu_in_s, exu_ent_s, lsu_ent_s, sel_ent_s;
  logic      exu_full_s, lsu_full_s;
  logic      exu_grant_s, lsu_grant_s, grant_s, wr_s;

  src_e            last_grant_q, last_grant_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            commit_valid_q, commit_valid_d;
  logic [XLEN-1:0] commit_pc_q, commit_pc_d;
  logic [31:0]     instret_q, instret_d;

  assign exu_in_s = '{rd: bus.exu_rd, wen: bus.exu_wen, data: bus.exu_data, pc: bus.exu_pc};
  assign lsu_in_s = '{rd: bus.lsu_rd, wen: bus.lsu_wen, data: bus.lsu_data, pc: bus.lsu_pc};

  ysyx_25060170_wb_buf u_exu_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.exu_valid),
    .in_ready (bus.exu_ready),
    .in_entry (exu_in_s),
    .drain    (exu_grant_s),
    .full     (exu_full_s),
    .entry    (exu_ent_s)
  );

  ysyx_25060170_wb_buf u_lsu_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.lsu_valid),
    .in_ready (bus.lsu_ready),
    .in_entry (lsu_in_s),
    .drain    (lsu_grant_s),
    .full     (lsu_full_s),
    .entry    (lsu_ent_s)
  );

  // Arbiter: a lone full buffer wins; with both full the one not granted last time wins.
  always_comb begin
    exu_grant_s = 1'b0;
    lsu_grant_s = 1'b0;
    case ({exu_full_s, lsu_full_s})
      2'b10: exu_grant_s = 1'b1;
      2'b01: lsu_grant_s = 1'b1;
      2'b11: begin
        if (last_grant_q == SRC_EXU) begin
          lsu_grant_s = 1'b1;
        end else begin
          exu_grant_s = 1'b1;
        end
      end
      default: begin
        exu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
      end
    endcase
    grant_s   = exu_grant_s || lsu_grant_s;
    sel_ent_s = lsu_grant_s ? lsu_ent_s : exu_ent_s;
    wr_s      = grant_s && sel_ent_s.wen && (sel_ent_s.rd != {RAW{1'b0}});
  end

  // Next-state for grant history, scoreboard and commit tracking; a same-cycle set beats the clear.
  always_comb begin
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    if (exu_grant_s) begin
      last_grant_d = SRC_EXU;
    end else if (lsu_grant_s) begin
      last_grant_d = SRC_LSU;
    end else begin
      last_grant_d = last_grant_q;
    end
    if (wr_s) begin
      busy_d[sel_ent_s.rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bus.iss_valid && (bus.iss_rd != {RAW{1'b0}})) begin
      busy_d[bus.iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0]      = 1'b0;
    commit_valid_d = grant_s;
    commit_pc_d    = grant_s ? sel_ent_s.pc : commit_pc_q;
    instret_d      = instret_q + {31'd0, grant_s};
  end

  // Unit state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q   <= SRC_EXU;
      busy_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= {XLEN{1'b0}};
      instret_q      <= 32'd0;
    end else begin
      last_grant_q   <= last_grant_d;
      busy_q         <= busy_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      instret_q      <= instret_d;
    end
  end

  assign bus.rf_waddr     = sel_ent_s.rd;
  assign bus.rf_wdata     = sel_ent_s.data;
  assign bus.rf_wen       = wr_s;
  assign bus.qry_busy1    = busy_q[bus.qry_raddr1];
  assign bus.qry_busy2    = busy_q[bus.qry_raddr2];
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc    = commit_pc_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Self-checking bench for the writeback unit: per-source expected-commit queues,
// a GPR model written from rf_*, and directed hazard/reset scenarios.
module tb_ysyx_25060170_wbu;
  import ysyx_25060170_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25060170_wbu_if bus ();

  ysyx_25060170_wbu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_commit = 0;
  logic [XLEN-1:0] gpr [NREG];
  wb_entry_t exu_q[$];
  wb_entry_t lsu_q[$];
  src_e      commit_src[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // GPR file model, written at the edge after rf_wen is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (bus.rf_wen) begin
      gpr[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // Commit monitor: match against the head of either source queue, then check the GPR value.
  always @(negedge clk) begin : mon
    wb_entry_t e;
    logic [XLEN-1:0] exp_pc;
    if (!rst && bus.commit_valid) begin
      if (exu_q.size() > 0 && exu_q[0].pc == bus.commit_pc) begin
        e = exu_q.pop_front();
        commit_src.push_back(SRC_EXU);
        n_commit++;
        if (e.rd == '0) check("x0_zero", gpr[0], 64'd0);
        else if (e.wen) check("commit_gpr", gpr[e.rd], e.data);
      end else if (lsu_q.size() > 0 && lsu_q[0].pc == bus.commit_pc) begin
        e = lsu_q.pop_front();
        commit_src.push_back(SRC_LSU);
        n_commit++;
        if (e.rd == '0) check("x0_zero", gpr[0], 64'd0);
        else if (e.wen) check("commit_gpr", gpr[e.rd], e.data);
      end else begin
        exp_pc = (exu_q.size() > 0) ? exu_q[0].pc :
                 (lsu_q.size() > 0) ? lsu_q[0].pc : 32'hFFFF_FFFF;
        check("commit_pc_expected", bus.commit_pc, exp_pc);
      end
    end
  end

  // IDU must not issue to a register still pending, unless it drains this very cycle.
  always @(posedge clk) begin
    if (!rst && bus.iss_valid && bus.iss_rd != '0) begin
      assert (!dut.busy_q[bus.iss_rd] || (bus.rf_wen && bus.rf_waddr == bus.iss_rd))
        else $error("issue to busy register x%0d", bus.iss_rd);
    end
  end

  task automatic send(input src_e s, input logic [RAW-1:0] rd, input logic wen,
                      input logic [XLEN-1:0] data, input logic [XLEN-1:0] pc, output int waits);
    logic rdy;
    wb_entry_t e;
    e = '{rd: rd, wen: wen, data: data, pc: pc};
    rdy = 1'b0;
    waits = 0;
    if (s == SRC_EXU) begin
      bus.exu_valid = 1'b1; bus.exu_rd = rd; bus.exu_wen = wen; bus.exu_data = data; bus.exu_pc = pc;
    end else begin
      bus.lsu_valid = 1'b1; bus.lsu_rd = rd; bus.lsu_wen = wen; bus.lsu_data = data; bus.lsu_pc = pc;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = (s == SRC_EXU) ? bus.exu_ready : bus.lsu_ready;
      @(posedge clk);
      if (rdy) break;
      waits++;
    end
    #1;
    if (rdy) begin
      if (s == SRC_EXU) exu_q.push_back(e);
      else lsu_q.push_back(e);
    end else begin
      check("handshake_timeout", {63'd0, rdy}, 64'd1);
    end
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 20; i++) begin
      if (exu_q.size() == 0 && lsu_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", exu_q.size() + lsu_q.size(), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exu_q.delete();
    lsu_q.delete();
    commit_src.delete();
    n_commit = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int w, we, wl, base;
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_wen = 1'b0; bus.exu_data = '0; bus.exu_pc = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_wen = 1'b0; bus.lsu_data = '0; bus.lsu_pc = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.qry_raddr1 = 5'd7; bus.qry_raddr2 = 5'd3;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_exu_ready", bus.exu_ready, 64'd0);
    check("rst_lsu_ready", bus.lsu_ready, 64'd0);
    check("rst_commit", bus.commit_valid, 64'd0);
    check("rst_commit_pc", bus.commit_pc, 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    step();
    rst = 1'b0;

    // Reset while an EXU entry is buffered and x3 is busy.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    check("busy3_set", bus.qry_busy2, 64'd1);
    step();
    send(SRC_EXU, 5'd3, 1'b1, 32'h55, 32'h300, w);
    rst = 1'b1;
    exu_q.delete();
    @(negedge clk);
    check("midrst_exu_ready", bus.exu_ready, 64'd0);
    check("midrst_lsu_ready", bus.lsu_ready, 64'd0);
    check("midrst_rf_wen", bus.rf_wen, 64'd0);
    check("midrst_busy", bus.qry_busy2, 64'd0);
    check("midrst_instret", bus.instret, 64'd0);
    step();
    bus.exu_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_commit", n_commit, 64'd0);
    check("midrst_instret_after", bus.instret, 64'd0);

    // Single EXU result.
    step();
    send(SRC_EXU, 5'd5, 1'b1, 32'hDEADBEEF, 32'h8000_0000, w);
    bus.exu_valid = 1'b0;
    @(negedge clk);
    check("t2_rf_wen", bus.rf_wen, 64'd1);
    check("t2_waddr", bus.rf_waddr, 64'd5);
    check("t2_wdata", bus.rf_wdata, 64'hDEADBEEF);
    @(negedge clk);
    check("t2_commit", bus.commit_valid, 64'd1);
    check("t2_commit_pc", bus.commit_pc, 64'h8000_0000);
    check("t2_instret", bus.instret, 64'd1);
    @(negedge clk);
    check("t2_pulse_one_cycle", bus.commit_valid, 64'd0);

    // rd=0 with wen=1: no write, still commits.
    step();
    send(SRC_EXU, 5'd0, 1'b1, 32'h1234, 32'h8000_0004, w);
    bus.exu_valid = 1'b0;
    @(negedge clk);
    check("t4_rf_wen", bus.rf_wen, 64'd0);
    @(negedge clk);
    check("t4_commit", bus.commit_valid, 64'd1);
    check("t4_instret", bus.instret, 64'd2);

    // Scoreboard set/clear, and set-wins on a same-cycle issue and drain.
    bus.qry_raddr2 = 5'd0;
    step();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step();
    bus.iss_rd = 5'd0;
    @(negedge clk);
    check("t5_busy7", bus.qry_busy1, 64'd1);
    step();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    check("t5_busy0", bus.qry_busy2, 64'd0);
    step();
    send(SRC_EXU, 5'd7, 1'b1, 32'h77, 32'h8000_0008, w);
    bus.exu_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_during_write", bus.qry_busy1, 64'd1);
    @(negedge clk);
    check("t5_busy_cleared", bus.qry_busy1, 64'd0);
    step();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step();
    bus.iss_valid = 1'b0;
    send(SRC_EXU, 5'd7, 1'b1, 32'h78, 32'h8000_000C, w);
    bus.exu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    check("t5_set_wins", bus.qry_busy1, 64'd1);
    drain_wait();

    // Both sources streaming: grants alternate, no loss or duplication.
    do_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) send(SRC_EXU, 5'(10 + i), 1'b1, 32'hE000 + 32'(i), 32'h1000_0000 + 32'(4 * i), we);
        bus.exu_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) send(SRC_LSU, 5'(13 + i), 1'b1, 32'hA000 + 32'(i), 32'h2000_0000 + 32'(4 * i), wl);
        bus.lsu_valid = 1'b0;
      end
    join
    drain_wait();
    @(negedge clk);
    check("t3_commits", n_commit, 64'd6);
    check("t3_instret", bus.instret, 64'd6);
    for (int i = 1; i < commit_src.size(); i++) begin
      check("t3_alternate", commit_src[i], (commit_src[i-1] == SRC_EXU) ? SRC_LSU : SRC_EXU);
    end

    // LSU drain-and-refill stream: never stalls, four back-to-back writes.
    base = n_commit;
    step();
    wl = 0;
    for (int i = 0; i < 4; i++) begin
      send(SRC_LSU, 5'(20 + i), 1'b1, 32'hC0DE_0000 + 32'(i), 32'h3000_0000 + 32'(4 * i), w);
      wl += w;
    end
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    check("t6_last_write", bus.rf_waddr, 64'd23);
    check("t6_no_stall", wl, 64'd0);
    drain_wait();
    @(negedge clk);
    check("t6_commits", n_commit - base, 64'd4);
    check("t6_instret", bus.instret, 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
